ext_mem_responder: RTL and testbench
====================================

// Module: ext_mem_responder
// PURPOSE
//   Target side of the external memory interface driven by dma_engine.
//   Accepts one read or write request at a time on the ext_read_*/ext_write_* valid/ready channels.
//   Services each request from an internal word array after a programmable latency.
//   Replies with a single-cycle ready pulse.
//   Serves as the external-memory model in GPU integration benches and as the on-chip backing store in FPGA builds.
// PARAMETERS
//   ADDR_BITS      8    external word-address width (matches dma_engine)
//   DATA_WIDTH     64   word width
//   MEM_WORDS      256  implemented words; legal addresses 0..MEM_WORDS-1 (MEM_WORDS <= 2**ADDR_BITS)
//   READ_LATENCY   2    cycles from read acceptance to ext_read_ready (>=1)
//   WRITE_LATENCY  1    cycles from write acceptance to ext_write_ready (>=1)
// PORTS
//   clk                clk     in   1           rising-edge clock
//   reset              reset   in   1           asynchronous, active-low reset
//   ext_read_valid     in   1           read request; held high until the ready pulse is seen
//   ext_read_address   in   ADDR_BITS   read word address
//   ext_read_ready     out  1           1-cycle pulse; read data valid in this cycle
//   ext_read_data      out  DATA_WIDTH  registered read data
//   ext_write_valid    in   1           write request
//   ext_write_address  in   ADDR_BITS   write word address
//   ext_write_data     in   DATA_WIDTH  write data
//   ext_write_ready    out  1           1-cycle pulse; write committed in this cycle
//   stall              in   1           freezes the latency counter while high (backpressure injection)
//   busy               out  1           high from acceptance through COOLDOWN
//   rd_count           out  16          completed reads; saturates at 16'hFFFF
//   wr_count           out  16          completed writes; saturates at 16'hFFFF
// BEHAVIOUR
//   Reset (reset=0, async)
//     - All outputs 0; state=IDLE; last_grant=WRITE, so the first tie goes to read.
//     - Memory array is not cleared.
//     - An in-flight request is dropped; its write is not committed.
//   FSM: IDLE -> RD_WAIT|WR_WAIT -> RESP -> COOLDOWN -> IDLE
//   IDLE
//     - Samples the valids; on acceptance latches op, address and write data.
//     - Loads the latency counter with LAT-1; sets busy.
//     - Both valids high: round-robin, grant the opposite of last_grant.
//     - Request inputs are ignored after acceptance until IDLE returns.
//   RD_WAIT / WR_WAIT
//     - Counter decrements each cycle while stall=0; at 0 go to RESP.
//     - stall=1 holds the counter and state.
//   RESP (exactly 1 cycle)
//     - Read: ext_read_ready=1, ext_read_data=mem[addr] (registered).
//     - Write: ext_write_ready=1, mem[addr]<=data.
//     - Increments rd_count/wr_count (saturating); updates last_grant.
//   COOLDOWN (1 cycle, ready=0)
//     - Absorbs an initiator whose valid deassert lags the ready pulse by one register stage.
//     - Guarantees no double service.
//     - Then IDLE; busy=0.
//   Latency
//     - Request accepted in IDLE cycle t gives ready in cycle t+LAT (no stall).
//     - Back-to-back requests are spaced LAT+2 cycles apart.
//   ext_read_data holds its last value between reads; it is defined only when ext_read_ready=1.
//   Address >= MEM_WORDS: read returns 0, write is discarded; the ready pulse still occurs.
//   stall asserted in IDLE has no effect; acceptance proceeds.
// CONFIGURATION
//   EXT_MEM_ADDR_CHECK_EN defined
//     - Adds ports addr_error (out, 1) and error_count (out, 8).
//     - addr_error pulses in the RESP cycle of any out-of-range access.
//     - error_count increments on each such access, saturates at 255, resets to 0.
//   EXT_MEM_ADDR_CHECK_EN undefined
//     - No extra ports; out-of-range accesses are silently handled as above.
// TESTING
//   1. Write 0xDEAD_BEEF_0000_0001 to addr 5, then read addr 5
//      -> write_ready at t+1; read_ready at t+2 with that data; wr_count=1, rd_count=1.
//   2. Both valids high in the same cycle after reset
//      -> read served first, write served next; both data verified via readback.
//   3. stall=1 for 3 cycles during RD_WAIT -> read_ready delayed exactly 3 cycles.
//   4. Valid held 1 cycle past the ready pulse
//      -> exactly one ready pulse; counters advance by exactly 1.
//   5. reset=0 in the middle of WR_WAIT to addr 9
//      -> outputs 0 immediately; mem[9] unchanged; wr_count=0.
//   6. MEM_WORDS=128, read addr 200
//      -> ready pulses with data 0; with EXT_MEM_ADDR_CHECK_EN: addr_error=1, error_count=1.

Source files
------------

// File: rtl/ext_mem_responder.sv
// External memory target: one outstanding read or write, serviced from a word array after a
// programmable latency. Define EXT_MEM_ADDR_CHECK_EN to add addr_error / error_count reporting.
module ext_mem_responder #(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned MEM_WORDS     = 256,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned WRITE_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ext_read_valid,
  input  logic [ADDR_BITS-1:0]  ext_read_address,
  output logic                  ext_read_ready,
  output logic [DATA_WIDTH-1:0] ext_read_data,
  input  logic                  ext_write_valid,
  input  logic [ADDR_BITS-1:0]  ext_write_address,
  input  logic [DATA_WIDTH-1:0] ext_write_data,
  output logic                  ext_write_ready,
  input  logic                  stall,
  output logic                  busy,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
`ifdef EXT_MEM_ADDR_CHECK_EN
  ,
  output logic                  addr_error,
  output logic [7:0]            error_count
`endif
);

  localparam int unsigned MaxLat = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned LatW   = $clog2(MaxLat + 1);
  localparam int unsigned IdxW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [LatW-1:0]    RdLatM1   = LatW'(READ_LATENCY - 1);
  localparam logic [LatW-1:0]    WrLatM1   = LatW'(WRITE_LATENCY - 1);
  localparam logic [ADDR_BITS:0] MemWordsW = MEM_WORDS[ADDR_BITS:0];

  typedef enum logic [2:0] {StIdle, StRdWait, StWrWait, StResp, StCooldown} state_e;

  state_e                state_q, state_d;
  logic                  op_rd_q, op_rd_d;
  logic                  in_range_q, in_range_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [LatW-1:0]       lat_q, lat_d;
  logic                  last_rd_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [15:0]           rd_count_q, wr_count_q;

  logic                  grant_rd;
  logic                  rd_in_range, wr_in_range;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  assign rd_in_range = ({1'b0, ext_read_address} < MemWordsW);
  assign wr_in_range = ({1'b0, ext_write_address} < MemWordsW);

  // last_rd_q resets to 0 (last grant = write), so the first tie goes to the read channel.
  assign grant_rd = ext_read_valid && !(ext_write_valid && last_rd_q);

  always_comb begin
    state_d    = state_q;
    op_rd_d    = op_rd_q;
    in_range_d = in_range_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    lat_d      = lat_q;
    unique case (state_q)
      StIdle: begin
        if (ext_read_valid || ext_write_valid) begin
          op_rd_d    = grant_rd;
          in_range_d = grant_rd ? rd_in_range : wr_in_range;
          idx_d      = grant_rd ? ext_read_address[IdxW-1:0] : ext_write_address[IdxW-1:0];
          wdata_d    = ext_write_data;
          lat_d      = grant_rd ? RdLatM1 : WrLatM1;
          // A latency of 1 leaves no wait cycles: respond in the very next cycle.
          if ((grant_rd ? RdLatM1 : WrLatM1) == '0) begin
            state_d = StResp;
          end else begin
            state_d = grant_rd ? StRdWait : StWrWait;
          end
        end
      end
      StRdWait, StWrWait: begin
        if (!stall) begin
          lat_d = lat_q - LatW'(1);
          if (lat_q == LatW'(1)) begin
            state_d = StResp;
          end
        end
      end
      StResp:     state_d = StCooldown;
      StCooldown: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      op_rd_q    <= 1'b0;
      in_range_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      lat_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_rd_q    <= op_rd_d;
      in_range_q <= in_range_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      lat_q      <= lat_d;
    end
  end

  // Read data is captured on the edge entering RESP so it is valid for the whole ready cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (state_d == StResp && op_rd_d) begin
      rdata_q <= in_range_d ? mem[idx_d] : '0;
    end
  end

  // Array has no reset; state_q is forced to StIdle by reset, so an in-flight write is dropped.
  always_ff @(posedge clk) begin
    if (state_q == StResp && !op_rd_q && in_range_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_rd_q  <= 1'b0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (state_q == StResp) begin
      last_rd_q <= op_rd_q;
      if (op_rd_q && rd_count_q != 16'hFFFF) begin
        rd_count_q <= rd_count_q + 16'd1;
      end
      if (!op_rd_q && wr_count_q != 16'hFFFF) begin
        wr_count_q <= wr_count_q + 16'd1;
      end
    end
  end

`ifdef EXT_MEM_ADDR_CHECK_EN
  logic [7:0] error_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error_count_q <= '0;
    end else if (state_q == StResp && !in_range_q && error_count_q != 8'hFF) begin
      error_count_q <= error_count_q + 8'd1;
    end
  end

  assign addr_error  = (state_q == StResp) && !in_range_q;
  assign error_count = error_count_q;
`endif

  assign ext_read_ready  = (state_q == StResp) && op_rd_q;
  assign ext_write_ready = (state_q == StResp) && !op_rd_q;
  assign ext_read_data   = rdata_q;
  assign busy            = (state_q != StIdle);
  assign rd_count        = rd_count_q;
  assign wr_count        = wr_count_q;

endmodule

// File: tb/tb_ext_mem_responder.sv
// Self-checking bench for ext_mem_responder: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ext_mem_responder;

  localparam int unsigned AB = 8;
  localparam int unsigned DW = 64;
  localparam int unsigned MW = 128;
  localparam int unsigned RL = 2;
  localparam int unsigned WL = 1;
  localparam int unsigned IW = $clog2(MW);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ext_read_valid = 1'b0;
  logic [AB-1:0] ext_read_address = '0;
  logic          ext_read_ready;
  logic [DW-1:0] ext_read_data;
  logic          ext_write_valid = 1'b0;
  logic [AB-1:0] ext_write_address = '0;
  logic [DW-1:0] ext_write_data = '0;
  logic          ext_write_ready;
  logic          stall = 1'b0;
  logic          busy;
  logic [15:0]   rd_count;
  logic [15:0]   wr_count;
`ifdef EXT_MEM_ADDR_CHECK_EN
  logic          addr_error;
  logic [7:0]    error_count;
`endif

  ext_mem_responder #(
    .ADDR_BITS    (AB),
    .DATA_WIDTH   (DW),
    .MEM_WORDS    (MW),
    .READ_LATENCY (RL),
    .WRITE_LATENCY(WL)
  ) u_dut (
    .clk              (clk),
    .reset            (reset),
    .ext_read_valid   (ext_read_valid),
    .ext_read_address (ext_read_address),
    .ext_read_ready   (ext_read_ready),
    .ext_read_data    (ext_read_data),
    .ext_write_valid  (ext_write_valid),
    .ext_write_address(ext_write_address),
    .ext_write_data   (ext_write_data),
    .ext_write_ready  (ext_write_ready),
    .stall            (stall),
    .busy             (busy),
    .rd_count         (rd_count),
    .wr_count         (wr_count)
`ifdef EXT_MEM_ADDR_CHECK_EN
    ,
    .addr_error       (addr_error),
    .error_count      (error_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] m_mem   [MW];
  bit            m_known [MW];
  bit            m_active = 0;
  bit            m_op_rd = 0;
  bit            m_last_rd = 0;
  longint        m_accept = 0;
  longint        m_resp = 0;
  logic [AB-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  int unsigned   m_rd_cnt = 0;
  int unsigned   m_wr_cnt = 0;
  int unsigned   m_err_cnt = 0;

  wire m_grant_rd = ext_read_valid && !(ext_write_valid && m_last_rd);
  wire m_oor      = int'(m_addr) >= int'(MW);

  // A request owns the target from acceptance until two cycles after its response.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active  <= 0;
      m_last_rd <= 0;
      m_rd_cnt  <= 0;
      m_wr_cnt  <= 0;
      m_err_cnt <= 0;
    end else begin
      if (m_active && cyc == m_resp) begin
        m_last_rd <= m_op_rd;
        if (m_op_rd && m_rd_cnt < 65535) m_rd_cnt <= m_rd_cnt + 1;
        if (!m_op_rd && m_wr_cnt < 65535) m_wr_cnt <= m_wr_cnt + 1;
        if (m_oor && m_err_cnt < 255) m_err_cnt <= m_err_cnt + 1;
        if (!m_op_rd && !m_oor) begin
          m_mem[m_addr[IW-1:0]]   <= m_wdata;
          m_known[m_addr[IW-1:0]] <= 1;
        end
      end
      if (!m_active || cyc >= m_resp + 2) begin
        m_active <= 0;
        if (ext_read_valid || ext_write_valid) begin
          m_active <= 1;
          m_op_rd  <= m_grant_rd;
          m_addr   <= m_grant_rd ? ext_read_address : ext_write_address;
          m_wdata  <= ext_write_data;
          m_accept <= cyc;
          m_resp   <= cyc + (m_grant_rd ? RL : WL);
        end
      end else if (cyc > m_accept && cyc < m_resp && stall) begin
        m_resp <= m_resp + 1;
      end
    end
  end

  wire           e_resp  = m_active && (cyc == m_resp);
  wire           e_rr    = e_resp && m_op_rd;
  wire           e_wr    = e_resp && !m_op_rd;
  wire           e_busy  = m_active && (cyc > m_accept) && (cyc <= m_resp + 1);
  wire           e_known = m_oor || m_known[m_addr[IW-1:0]];
  wire [DW-1:0]  e_data  = m_oor ? '0 : m_mem[m_addr[IW-1:0]];

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en && reset) begin
      check("read_ready", ext_read_ready, e_rr);
      check("write_ready", ext_write_ready, e_wr);
      check("busy", busy, e_busy);
      check("rd_count", rd_count, m_rd_cnt);
      check("wr_count", wr_count, m_wr_cnt);
      if (e_rr && e_known) check("read_data", ext_read_data, e_data);
`ifdef EXT_MEM_ADDR_CHECK_EN
      check("addr_error", addr_error, e_resp && m_oor);
      check("error_count", error_count, m_err_cnt);
`endif
    end
  end

  // ---------------- initiator ----------------
  // Called #1 after a rising edge; holds each valid until its ready pulse (plus `lag` cycles).
  task automatic req(input bit rd, input logic [AB-1:0] ra, input bit wr, input logic [AB-1:0] wa,
                     input logic [DW-1:0] wd, input int lag, input bit rnd_stall,
                     input int st_from, input int st_len, output longint t0, output longint t_rr,
                     output longint t_wr, output logic [DW-1:0] rdat);
    bit rp, wp;
    int rl, wl, n;
    longint k;
    rp = rd; wp = wr; rl = 0; wl = 0; n = 0;
    t0 = cyc; t_rr = -1; t_wr = -1; rdat = '0;
    ext_read_valid = rd; ext_read_address = ra;
    ext_write_valid = wr; ext_write_address = wa; ext_write_data = wd;
    stall = rnd_stall ? ($urandom_range(3) == 0) : (st_from == 0 && st_len > 0);
    while ((ext_read_valid || ext_write_valid) && n < 200) begin
      @(negedge clk);
      if (rp && ext_read_ready) begin rp = 0; t_rr = cyc; rl = lag; rdat = ext_read_data; end
      if (wp && ext_write_ready) begin wp = 0; t_wr = cyc; wl = lag; end
      @(posedge clk);
      #1;
      n++;
      k = cyc - t0;
      stall = rnd_stall ? ($urandom_range(3) == 0) : (k >= st_from && k < st_from + st_len);
      if (!rp && ext_read_valid) begin
        if (rl == 0) ext_read_valid = 0; else rl--;
      end
      if (!wp && ext_write_valid) begin
        if (wl == 0) ext_write_valid = 0; else wl--;
      end
    end
    stall = 0;
    if (ext_read_valid || ext_write_valid) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: no ready after %0d cycles, required a ready pulse", n);
      ext_read_valid = 0;
      ext_write_valid = 0;
    end
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  longint        t0, trr, twr;
  logic [DW-1:0] rdat, old9, d20;
  logic [AB-1:0] ra, wa;
  int            kind, gap;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_read_ready", ext_read_ready, 0);
    check("rst_write_ready", ext_write_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_count", rd_count, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_read_data", ext_read_data, 0);
`ifdef EXT_MEM_ADDR_CHECK_EN
    check("rst_error_count", error_count, 0);
`endif
    reset = 1;
    chk_en = 1;

    // Write then read back address 5.
    req(0, '0, 1, 8'd5, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 0, t0, trr, twr, rdat);
    check("t1_write_latency", 64'(twr - t0), 1);
    settle();
    req(1, 8'd5, 0, '0, '0, 0, 0, 0, 0, t0, trr, twr, rdat);
    check("t1_read_latency", 64'(trr - t0), 2);
    check("t1_read_data", rdat, 64'hDEAD_BEEF_0000_0001);
    check("t1_rd_count", rd_count, 1);
    check("t1_wr_count", wr_count, 1);

    // Three stalled wait cycles add exactly three cycles; stall in idle adds nothing.
    settle();
    req(1, 8'd5, 0, '0, '0, 0, 0, 1, 3, t0, trr, twr, rdat);
    check("t3_stall_latency", 64'(trr - t0), 5);
    settle();
    req(1, 8'd5, 0, '0, '0, 0, 0, 0, 1, t0, trr, twr, rdat);
    check("t3_idle_stall_latency", 64'(trr - t0), 2);

    // Valid held one cycle past ready: served once only.
    settle();
    req(1, 8'd5, 0, '0, '0, 1, 0, 0, 0, t0, trr, twr, rdat);
    repeat (3) @(posedge clk);
    #1;
    check("t4_rd_count", rd_count, 4);
    check("t4_wr_count", wr_count, 1);

    for (int i = 0; i < int'(MW); i++) begin
      req(0, '0, 1, AB'(i), {$urandom, $urandom}, 0, 1, 0, 0, t0, trr, twr, rdat);
    end

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(2);
      ra = ($urandom_range(9) == 0) ? AB'($urandom_range(255, MW)) : AB'($urandom_range(MW - 1));
      wa = ($urandom_range(9) == 0) ? AB'($urandom_range(255, MW)) : AB'($urandom_range(MW - 1));
      req(kind != 1, ra, kind != 0, wa, {$urandom, $urandom}, $urandom_range(1), 1, 0, 0,
          t0, trr, twr, rdat);
      gap = $urandom_range(3);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end

    // Reset while a write to address 9 is in flight: it must not commit.
    settle();
    old9 = m_mem[9];
    ext_write_valid = 1; ext_write_address = 8'd9; ext_write_data = ~old9;
    @(posedge clk);
    #1;
    reset = 0;
    ext_write_valid = 0;
    #1;
    check("t5_read_ready", ext_read_ready, 0);
    check("t5_write_ready", ext_write_ready, 0);
    check("t5_busy", busy, 0);
    check("t5_rd_count", rd_count, 0);
    check("t5_wr_count", wr_count, 0);
    check("t5_read_data", ext_read_data, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1;

    // First tie after reset goes to the read.
    d20 = {$urandom, $urandom};
    req(1, 8'd9, 1, 8'd20, d20, 0, 0, 0, 0, t0, trr, twr, rdat);
    check("t2_read_first", 64'(trr - t0), RL);
    check("t2_write_second", 64'(twr - t0), RL + 2 + WL);
    check("t5_mem9_unchanged", rdat, old9);
    settle();
    req(1, 8'd20, 0, '0, '0, 0, 0, 0, 0, t0, trr, twr, rdat);
    check("t2_readback", rdat, d20);

    // Out-of-range read.
    settle();
    req(1, 8'd200, 0, '0, '0, 0, 0, 0, 0, t0, trr, twr, rdat);
    check("t6_oor_latency", 64'(trr - t0), RL);
    check("t6_oor_data", rdat, 0);
    settle();
    check("t6_rd_count", rd_count, 3);
    check("t6_wr_count", wr_count, 1);
`ifdef EXT_MEM_ADDR_CHECK_EN
    check("t6_error_count", error_count, 1);
`endif

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
